// File: rtl/cache_line_writeback.sv
// Copies one cache line from the data RAM to memory, one word per bus write.
// Registered RAM read, single outstanding bus write, abort on bus error.
module cache_line_writeback #(
  parameter int unsigned nr_entries     = 32,
  parameter int unsigned words_per_line = 8
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  start,
  input  logic [$clog2(nr_entries)-$clog2(words_per_line)-1:0] cache_index,
  input  logic [31:0]                                           mem_base,
  output logic                                                  busy,
  output logic                                                  done,
  output logic                                                  error,
  output logic [$clog2(nr_entries)-1:0]                         ram_read_addr,
  input  logic [31:0]                                           ram_read_data,
  output logic                                                  m_access,
  output logic                                                  m_wr_en,
  output logic [31:0]                                           m_addr,
  output logic [31:0]                                           m_data,
  output logic [3:0]                                            m_bytesel,
  input  logic                                                  m_ack,
  input  logic                                                  m_error
);

  localparam int unsigned addr_bits  = $clog2(nr_entries);
  localparam int unsigned word_bits  = $clog2(words_per_line);
  localparam int unsigned index_bits = addr_bits - word_bits;

  // Byte offset bits inside a line are forced to zero on capture.
  localparam logic [31:0]          base_mask = ~((32'd1 << (word_bits + 2)) - 32'd1);
  localparam logic [word_bits-1:0] last_word = word_bits'(words_per_line - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [index_bits-1:0] index_reg;
  logic [index_bits-1:0] index_next;
  logic [31:0]           mem_base_reg;
  logic [31:0]           base_next;
  logic [word_bits-1:0]  word_cnt;
  logic [word_bits-1:0]  cnt_next;
  logic                  error_next;
  logic                  busy_next;
  logic                  done_next;
  logic                  access_next;
  logic [31:0]           addr_next;
  logic [31:0]           data_next;

  assign ram_read_addr = {index_reg, word_cnt};

  // Next-state and next-register values; outputs decoded from the next state.
  always_comb begin
    state_next  = state;
    index_next  = index_reg;
    base_next   = mem_base_reg;
    cnt_next    = word_cnt;
    error_next  = error;
    addr_next   = m_addr;
    data_next   = m_data;

    unique case (state)
      IDLE: begin
        if (start) begin
          index_next = cache_index;
          base_next  = mem_base & base_mask;
          cnt_next   = '0;
          error_next = 1'b0;
          state_next = READ;
        end
      end
      READ: state_next = CAPTURE;
      CAPTURE: begin
        data_next  = ram_read_data;
        addr_next  = mem_base_reg + 32'({word_cnt, 2'b00});
        state_next = WRITE;
      end
      WRITE: begin
        if (m_error) begin
          error_next = 1'b1;
          state_next = DONE;
        end else if (m_ack) begin
          if (word_cnt == last_word) begin
            state_next = DONE;
          end else begin
            cnt_next   = word_cnt + word_bits'(1);
            state_next = READ;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next   = (state_next != IDLE);
    done_next   = (state_next == DONE);
    access_next = (state_next == WRITE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      index_reg    <= '0;
      mem_base_reg <= '0;
      word_cnt     <= '0;
      error        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      m_access     <= 1'b0;
      m_wr_en      <= 1'b0;
      m_bytesel    <= 4'b0000;
      m_addr       <= '0;
      m_data       <= '0;
    end else begin
      state        <= state_next;
      index_reg    <= index_next;
      mem_base_reg <= base_next;
      word_cnt     <= cnt_next;
      error        <= error_next;
      busy         <= busy_next;
      done         <= done_next;
      m_access     <= access_next;
      m_wr_en      <= access_next;
      m_bytesel    <= {4{access_next}};
      m_addr       <= addr_next;
      m_data       <= data_next;
    end
  end

endmodule

// File: tb/tb_cache_line_writeback.sv
// Bench for cache_line_writeback: schedule model, RAM and bus responder,
// per-cycle compare plus literal expectations for the directed scenarios.
module tb_cache_line_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  cache_index;
  logic [31:0] mem_base;
  logic        busy, done, error;
  logic [4:0]  ram_read_addr;
  logic [31:0] ram_read_data;
  logic        m_access, m_wr_en;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_bytesel;
  logic        m_ack, m_error;

  cache_line_writeback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cache_index(cache_index),
    .mem_base(mem_base), .busy(busy), .done(done), .error(error),
    .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data),
    .m_access(m_access), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_data(m_data),
    .m_bytesel(m_bytesel), .m_ack(m_ack), .m_error(m_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];
  int  wait_cfg [8];
  int  err_word = -1;
  bit  noise_en = 1'b0;

  // Model: per-transfer schedule of cycles relative to the accepting edge.
  int  cyc = 0;
  int  t0 = 0;
  bit  active = 1'b0;
  bit  has_err = 1'b0;
  bit  err_state = 1'b0;
  int  done_t = 0;
  int  rd_word [128];
  int  wr_word [128];
  logic [1:0]  m_idx = 2'd0;
  logic [31:0] m_base = 32'd0;

  logic [31:0] obs_addr [$];
  logic [31:0] obs_data [$];
  int  obs_done_t = -1;
  int  done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge.
  initial begin
    for (int i = 0; i < 128; i++) begin rd_word[i] = -1; wr_word[i] = -1; end
    forever begin
      int  tcur;
      int  s;
      bit  idle;
      @(posedge clk);
      if (!rst_n) begin
        active = 1'b0;
        err_state = 1'b0;
        cyc++;
      end else begin
        tcur = cyc - t0 + 1;
        idle = !active || (tcur > done_t);
        cyc++;
        if (idle && start === 1'b1) begin
          for (int i = 0; i < 128; i++) begin rd_word[i] = -1; wr_word[i] = -1; end
          s = 1;
          has_err = 1'b0;
          done_t = 0;
          for (int k = 0; k < 8 && done_t == 0; k++) begin
            rd_word[s] = k;
            for (int j = 0; j <= wait_cfg[k]; j++) wr_word[s + 2 + j] = k;
            if (k == err_word) begin
              has_err = 1'b1;
              done_t = s + 3 + wait_cfg[k];
            end
            s += 3 + wait_cfg[k];
          end
          if (!has_err) done_t = s;
          m_idx = cache_index;
          m_base = mem_base & 32'hFFFF_FFE0;
          err_state = 1'b0;
          active = 1'b1;
          t0 = cyc;
        end else if (active && (cyc - t0 + 1) == done_t && has_err) begin
          err_state = 1'b1;
        end
      end
    end
  end

  // Registered-read RAM.
  initial forever begin
    @(posedge clk);
    ram_read_data <= mem[ram_read_addr];
  end

  // Bus responder: wait_cfg cycles of stall per word, error on err_word.
  initial begin
    int wcnt;
    int wi;
    wcnt = 0;
    m_ack = 1'b0;
    m_error = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (m_access === 1'b1) begin
        wi = int'(m_addr[4:2]);
        if (wcnt >= wait_cfg[wi]) begin
          m_ack = 1'b1;
          m_error = (wi == err_word);
          obs_addr.push_back(m_addr);
          obs_data.push_back(m_data);
          wcnt = 0;
        end else begin
          m_ack = 1'b0;
          m_error = 1'b0;
          wcnt++;
        end
      end else begin
        wcnt = 0;
        m_ack = noise_en;
        m_error = noise_en;
      end
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    int t;
    int k;
    bit live;
    logic [4:0] exp_ra;
    @(negedge clk);
    t = cyc - t0 + 1;
    live = rst_n && active && t >= 1 && t <= done_t && t < 128;
    k = live ? wr_word[t] : -1;
    check("busy", 32'(busy), 32'(live));
    check("done", 32'(done), 32'(live && t == done_t));
    check("error", 32'(error), 32'(rst_n && err_state));
    check("m_access", 32'(m_access), 32'(k >= 0));
    check("m_wr_en", 32'(m_wr_en), 32'(k >= 0));
    check("m_bytesel", 32'(m_bytesel), (k >= 0) ? 32'hF : 32'h0);
    if (k >= 0) begin
      check("m_addr", m_addr, m_base + 32'(4 * k));
      check("m_data", m_data, mem[{m_idx, 3'(k)}]);
    end
    if (live && rd_word[t] >= 0) begin
      exp_ra = {m_idx, 3'(rd_word[t])};
      check("ram_read_addr", 32'(ram_read_addr), 32'(exp_ra));
    end
    if (done === 1'b1) begin
      done_cnt++;
      obs_done_t = t;
    end
  end

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic run_line(input logic [1:0] idx, input logic [31:0] base);
    obs_addr.delete();
    obs_data.delete();
    obs_done_t = -1;
    @(negedge clk);
    start = 1'b1;
    cache_index = idx;
    mem_base = base;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_m_access"}, 32'(m_access), 32'd0);
    check({tag, "_m_wr_en"}, 32'(m_wr_en), 32'd0);
    check({tag, "_m_bytesel"}, 32'(m_bytesel), 32'd0);
    check({tag, "_m_addr"}, m_addr, 32'd0);
    check({tag, "_m_data"}, m_data, 32'd0);
    check({tag, "_ram_read_addr"}, 32'(ram_read_addr), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    bit found;
    rst_n = 1'b0;
    start = 1'b0;
    cache_index = 2'd0;
    mem_base = 32'd0;
    for (int j = 0; j < 32; j++)
      mem[j] = (j >= 8 && j < 16) ? 32'h1000_0000 + 32'(j - 8) : 32'hA000_0000 + 32'(j);
    for (int k = 0; k < 8; k++) wait_cfg[k] = 0;
    #1;
    check_reset_values("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait line 1 to 0x2000.
    run_line(2'd1, 32'h0000_2000);
    check("t1_done_cycle", 32'(obs_done_t), 32'd25);
    check("t1_nwrites", 32'(obs_addr.size()), 32'd8);
    check("t1_addr0", obs_addr[0], 32'h0000_2000);
    check("t1_data0", obs_data[0], 32'h1000_0000);
    check("t1_addr7", obs_addr[7], 32'h0000_201C);
    check("t1_data7", obs_data[7], 32'h1000_0007);
    check("t1_error", 32'(error), 32'd0);

    // Five stall cycles on word 3.
    wait_cfg[3] = 5;
    run_line(2'd1, 32'h0000_2000);
    wait_cfg[3] = 0;
    check("t2_done_cycle", 32'(obs_done_t), 32'd30);
    check("t2_addr3", obs_addr[3], 32'h0000_200C);
    check("t2_data3", obs_data[3], 32'h1000_0003);

    // Bus error on word 2.
    err_word = 2;
    run_line(2'd1, 32'h0000_2000);
    err_word = -1;
    check("t3_nwrites", 32'(obs_addr.size()), 32'd3);
    check("t3_done_cycle", 32'(obs_done_t), 32'd10);
    repeat (3) @(negedge clk);
    check("t3_error_held", 32'(error), 32'd1);

    // Top line at the top of the address space; error clears on start.
    run_line(2'd3, 32'hFFFF_FFE0);
    check("t6_error_cleared", 32'(error), 32'd0);
    check("t6_done_cycle", 32'(obs_done_t), 32'd25);
    check("t6_data0", obs_data[0], 32'hA000_0018);
    check("t6_addr7", obs_addr[7], 32'hFFFF_FFFC);
    check("t6_data7", obs_data[7], 32'hA000_001F);

    // Unaligned base: offset bits are dropped.
    run_line(2'd0, 32'h0000_301C);
    check("t7_addr0", obs_addr[0], 32'h0000_3000);
    check("t7_data0", obs_data[0], 32'hA000_0000);

    // Start pulses while busy, with spurious ack/error outside WRITE.
    noise_en = 1'b1;
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk);
    start = 1'b1; cache_index = 2'd1; mem_base = 32'h0000_2000;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (m_access === 1'b1 && m_addr[4:2] == 3'd4) found = 1'b1;
    end
    check("t4_found_word4", 32'(found), 32'd1);
    start = 1'b1; cache_index = 2'd2; mem_base = 32'h0000_5000;
    @(negedge clk);
    start = 1'b0; cache_index = 2'd1; mem_base = 32'h0000_2000;
    wait_done();
    start = 1'b1; cache_index = 2'd2; mem_base = 32'h0000_5000;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy_after", 32'(busy), 32'd0);
    check("t4_nwrites", 32'(obs_addr.size()), 32'd8);
    check("t4_addr7", obs_addr[7], 32'h0000_201C);
    repeat (2) @(negedge clk);
    noise_en = 1'b0;

    // Reset during CAPTURE of word 5.
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk);
    start = 1'b1; cache_index = 2'd1; mem_base = 32'h0000_2000;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      int t;
      @(negedge clk);
      t = cyc - t0 + 1;
      if (t >= 1 && t < 128 && rd_word[t] == 5) found = 1'b1;
    end
    check("t5_found_read5", 32'(found), 32'd1);
    @(negedge clk);
    check("t5_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("t5");
    @(negedge clk);
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (30) @(negedge clk);
    check("t5_no_done", 32'(done_cnt), 32'(dc));
    check("t5_nwrites", 32'(obs_addr.size()), 32'd5);
    check("t5_busy_after", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
